// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, oversampling rate and the
// baud-select to divisor mapping used by both ends of the link.
package uart_pkg;

  localparam int unsigned OS_RATE = 16;
  localparam int unsigned DIV_W   = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } rx_state_t;

  // Unsupported baud selects fall back to 9600.
  function automatic logic [DIV_W-1:0] baud_to_div(input logic [16:0] baud,
                                                    input int unsigned clk_freq);
    int unsigned rate;
    case (baud)
      17'd4800, 17'd9600, 17'd14400, 17'd19200,
      17'd38400, 17'd57600, 17'd115200, 17'd128000: rate = 32'(baud);
      default:                                      rate = 32'd9600;
    endcase
    return DIV_W'(clk_freq / (OS_RATE * rate));
  endfunction

endpackage

// File: rtl/uart_os_tick.sv
// Oversampling clock-enable generator: one-cycle tick every div clocks,
// restartable via clear so the sample phase aligns to a detected start edge.
module uart_os_tick
  import uart_pkg::*;
#(
  parameter int unsigned W = DIV_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clear,
  input  logic [W-1:0] div,
  output logic         tick
);

  logic [W-1:0] count;

  assign tick = en && !clear && (count == div - W'(1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en) begin
      if (tick) count <= '0;
      else      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/uart_rx_os.sv
// 16x oversampling UART receiver with optional parity, stop/break handling
// and a valid/ready output register with overrun indication.
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 100_000_000,
  parameter int unsigned DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [16:0]          baud,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  input  logic                 rx,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int unsigned BC_W = $clog2(DATA_BITS + 1);
  localparam logic [3:0]  MID  = 4'(OS_RATE / 2 - 1);
  localparam logic [3:0]  LAST = 4'(OS_RATE - 1);

  rx_state_t            state;
  logic                 rx_meta, rx_sync, rx_prev;
  logic [DIV_W-1:0]     div_q;
  logic                 par_en_q, par_odd_q;
  logic [3:0]           tcnt;
  logic [BC_W-1:0]      bcnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 frame_perr, frame_ferr;
  logic                 done;
  logic                 tick;
  logic                 start_det;
  logic                 slot_end;

  assign start_det = (state == IDLE) && rx_prev && !rx_sync;
  assign slot_end  = tick && (tcnt == LAST);
  assign busy      = (state != IDLE);

  uart_os_tick #(.W(DIV_W)) u_tick (
    .clk   (clk),
    .rst   (rst),
    .en    (busy),
    .clear (start_det),
    .div   (div_q),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta    <= 1'b1;
      rx_sync    <= 1'b1;
      rx_prev    <= 1'b1;
      state      <= IDLE;
      div_q      <= baud_to_div(17'd9600, CLK_FREQ);
      par_en_q   <= 1'b0;
      par_odd_q  <= 1'b0;
      tcnt       <= '0;
      bcnt       <= '0;
      shreg      <= '0;
      frame_perr <= 1'b0;
      frame_ferr <= 1'b0;
      done       <= 1'b0;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
      done    <= 1'b0;
      case (state)
        IDLE: begin
          if (start_det) begin
            state      <= START;
            tcnt       <= '0;
            bcnt       <= '0;
            div_q      <= baud_to_div(baud, CLK_FREQ);
            par_en_q   <= parity_en;
            par_odd_q  <= parity_odd;
            frame_perr <= 1'b0;
          end
        end
        START: begin
          if (tick) begin
            if (tcnt == MID) begin
              tcnt  <= '0;
              state <= rx_sync ? IDLE : DATA;
            end else begin
              tcnt <= tcnt + 4'd1;
            end
          end
        end
        DATA: begin
          if (slot_end) begin
            tcnt  <= '0;
            shreg <= {rx_sync, shreg[DATA_BITS-1:1]};
            if (bcnt == BC_W'(DATA_BITS - 1)) begin
              bcnt  <= '0;
              state <= par_en_q ? PARITY : STOP;
            end else begin
              bcnt <= bcnt + BC_W'(1);
            end
          end else if (tick) begin
            tcnt <= tcnt + 4'd1;
          end
        end
        PARITY: begin
          if (slot_end) begin
            tcnt       <= '0;
            frame_perr <= ((^shreg) ^ rx_sync) != par_odd_q;
            state      <= STOP;
          end else if (tick) begin
            tcnt <= tcnt + 4'd1;
          end
        end
        STOP: begin
          if (slot_end) begin
            tcnt       <= '0;
            frame_ferr <= !rx_sync;
            done       <= 1'b1;
            state      <= rx_sync ? IDLE : BREAK;
          end else if (tick) begin
            tcnt <= tcnt + 4'd1;
          end
        end
        BREAK: begin
          if (rx_sync) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A completed frame is only loaded if the holding register is free or
  // being drained this same cycle; otherwise it is dropped with an overrun.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (done) begin
        if (!rx_valid || rx_ready) begin
          rx_data    <= shreg;
          parity_err <= frame_perr;
          frame_err  <= frame_ferr;
          rx_valid   <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed + randomized bench for uart_rx_os: frames are generated at bit
// level and compared against expectations computed from the frame contents.
module tb_uart_rx_os;

  localparam int unsigned CLK = 10_000_000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [16:0] baud = 17'd115200;
  logic        parity_en = 1'b0;
  logic        parity_odd = 1'b0;
  logic        rx = 1'b1;
  logic        rx_ready = 1'b0;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        parity_err;
  logic        frame_err;
  logic        overrun;
  logic        busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int rises = 0;
  int ovr_cycles = 0;
  int t_rise = 0;
  int t_start = 0;
  logic valid_d = 1'b0;

  uart_rx_os #(.CLK_FREQ(CLK), .DATA_BITS(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .baud       (baud),
    .parity_en  (parity_en),
    .parity_odd (parity_odd),
    .rx         (rx),
    .rx_ready   (rx_ready),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc++;
    #1;
    if (rx_valid && !valid_d) begin
      rises++;
      t_rise = cyc;
    end
    valid_d = rx_valid;
    if (overrun) ovr_cycles++;
  end

  function automatic int model_div(input int unsigned b);
    if (b inside {4800, 9600, 14400, 19200, 38400, 57600, 115200, 128000})
      return int'(CLK / (16 * b));
    return int'(CLK / (16 * 9600));
  endfunction

  function automatic logic model_perr(input logic [7:0] d, input logic pen,
                                      input logic podd, input logic pbit);
    int ones;
    if (!pen) return 1'b0;
    ones = $countones(d) + int'(pbit);
    return (ones % 2) != int'(podd);
  endfunction

  function automatic logic [16:0] any_baud();
    int unsigned sel;
    sel = $urandom_range(0, 8);
    case (sel)
      0: return 17'd4800;    1: return 17'd9600;   2: return 17'd14400;
      3: return 17'd19200;   4: return 17'd38400;  5: return 17'd57600;
      6: return 17'd115200;  7: return 17'd128000;
      default: return 17'd12345;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives one frame; baud input is scrambled after the start bit to show
  // the receiver uses the rate latched at start detection.
  task automatic send_frame(input logic [7:0] d, input logic pen, input logic pbit,
                            input logic stop_lvl, input int bitlen);
    @(negedge clk);
    rx = 1'b0;
    t_start = cyc;
    wait_cycles(bitlen);
    baud = any_baud();
    parity_en = $urandom_range(0, 1);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      wait_cycles(bitlen);
    end
    if (pen) begin
      rx = pbit;
      wait_cycles(bitlen);
    end
    rx = stop_lvl;
    wait_cycles(bitlen);
  endtask

  task automatic accept();
    @(negedge clk);
    rx_ready = 1'b1;
    @(negedge clk);
    check("valid_drop", 32'(rx_valid), 32'd0);
    rx_ready = 1'b0;
  endtask

  task automatic frame_and_check(input logic [7:0] d, input logic pen, input logic podd,
                                 input logic pbit, input logic [16:0] b);
    int bitlen;
    int r0;
    bitlen = 16 * model_div(32'(b));
    baud = b;
    parity_en = pen;
    parity_odd = podd;
    r0 = rises;
    send_frame(d, pen, pbit, 1'b1, bitlen);
    wait_cycles(2);
    check("valid_rise", 32'(rises - r0), 32'd1);
    check("valid", 32'(rx_valid), 32'd1);
    check("data", 32'(rx_data), 32'(d));
    check("parity_err", 32'(parity_err), 32'(model_perr(d, pen, podd, pbit)));
    check("frame_err", 32'(frame_err), 32'd0);
    accept();
    wait_cycles(bitlen);
  endtask

  initial begin
    int div;
    int lat;
    int r0;
    int o0;
    int bitlen;
    logic [7:0] d;
    logic pen, podd, pbit;
    logic [16:0] rb;

    // Reset values
    wait_cycles(4);
    check("rst_data", 32'(rx_data), 32'd0);
    check("rst_valid", 32'(rx_valid), 32'd0);
    check("rst_perr", 32'(parity_err), 32'd0);
    check("rst_ferr", 32'(frame_err), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b1;
    wait_cycles(20);

    // Basic 0xA5 at 115200 with latency check
    frame_and_check(8'hA5, 1'b0, 1'b0, 1'b0, 17'd115200);
    div = model_div(115200);
    lat = t_rise - t_start;
    check("latency_115200", 32'((lat >= 152*div+1-div) && (lat <= 152*div+1+div+3)), 32'd1);

    // Randomized frames over the faster rates and random parity settings
    for (int n = 0; n < 6; n++) begin
      d = 8'($urandom);
      pen = 1'($urandom);
      podd = 1'($urandom);
      pbit = 1'($urandom);
      case ($urandom_range(0, 4))
        0: rb = 17'd115200;
        1: rb = 17'd128000;
        2: rb = 17'd57600;
        3: rb = 17'd38400;
        default: rb = 17'd19200;
      endcase
      frame_and_check(d, pen, podd, pbit, rb);
    end

    // Even parity at 9600: good then bad parity bit
    frame_and_check(8'h3C, 1'b1, 1'b0, 1'b0, 17'd9600);
    frame_and_check(8'h3C, 1'b1, 1'b0, 1'b1, 17'd9600);

    // Glitch shorter than half a bit is rejected as a false start
    baud = 17'd115200;
    parity_en = 1'b0;
    div = model_div(115200);
    r0 = rises;
    @(negedge clk);
    rx = 1'b0;
    wait_cycles((16 * div * 3) / 10);
    rx = 1'b1;
    check("glitch_busy", 32'(busy), 32'd1);
    wait_cycles(8 * div + 10);
    check("glitch_idle", 32'(busy), 32'd0);
    check("glitch_novalid", 32'(rises - r0), 32'd0);
    frame_and_check(8'h55, 1'b0, 1'b0, 1'b0, 17'd115200);

    // Break: stop bit held low for 3 bit times
    bitlen = 16 * div;
    baud = 17'd115200;
    parity_en = 1'b0;
    r0 = rises;
    send_frame(8'h00, 1'b0, 1'b0, 1'b0, bitlen);
    baud = 17'd115200;
    check("brk_valid", 32'(rx_valid), 32'd1);
    check("brk_data", 32'(rx_data), 32'd0);
    check("brk_ferr", 32'(frame_err), 32'd1);
    check("brk_perr", 32'(parity_err), 32'd0);
    accept();
    wait_cycles(2 * bitlen);
    check("brk_no_second", 32'(rises - r0), 32'd1);
    check("brk_busy", 32'(busy), 32'd1);
    rx = 1'b1;
    wait_cycles(6);
    check("brk_release", 32'(busy), 32'd0);
    wait_cycles(bitlen);
    frame_and_check(8'h81, 1'b0, 1'b0, 1'b0, 17'd115200);

    // Overrun: second frame arrives while first is unaccepted
    rx_ready = 1'b0;
    baud = 17'd115200;
    parity_en = 1'b0;
    send_frame(8'h11, 1'b0, 1'b0, 1'b1, bitlen);
    baud = 17'd115200;
    parity_en = 1'b0;
    wait_cycles(bitlen);
    r0 = rises;
    o0 = ovr_cycles;
    send_frame(8'h22, 1'b0, 1'b0, 1'b1, bitlen);
    wait_cycles(10);
    check("ovr_pulse", 32'(ovr_cycles - o0), 32'd1);
    check("ovr_data_kept", 32'(rx_data), 32'h11);
    check("ovr_valid", 32'(rx_valid), 32'd1);
    check("ovr_norise", 32'(rises - r0), 32'd0);
    accept();
    wait_cycles(bitlen);

    // Reset mid-data aborts the frame
    baud = 17'd57600;
    parity_en = 1'b0;
    bitlen = 16 * model_div(57600);
    r0 = rises;
    @(negedge clk);
    rx = 1'b0;
    wait_cycles(bitlen);
    rx = 1'b1;
    wait_cycles(3 * bitlen + bitlen / 2);
    check("mid_busy", 32'(busy), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_valid", 32'(rx_valid), 32'd0);
    wait_cycles(3);
    rst = 1'b1;
    wait_cycles(6 * bitlen);
    check("abort_novalid", 32'(rises - r0), 32'd0);
    check("abort_idle", 32'(busy), 32'd0);

    // Unsupported baud select runs at the 9600 rate
    frame_and_check(8'h42, 1'b0, 1'b0, 1'b0, 17'd12345);
    div = model_div(12345);
    lat = t_rise - t_start;
    check("latency_default", 32'((lat >= 152*div+1-div) && (lat <= 152*div+1+div+3)), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_os.md
Name: uart_rx_os

Overview:
UART receiver, the consuming end of the serial link driven by the team's transmitter. The divider runs as clock enables from the single system clock; it does not create a derived rx clock. It oversamples the line 16x per bit, uses the same baud-select encoding as the clock generator, and validates the start bit at mid-bit. It checks optional parity and the stop bit, then presents each byte on a valid/ready interface to the host-side logic.

Parameters:
CLK_FREQ, 100_000_000, system clock frequency in Hz; divisor table is derived from it.
DATA_BITS, 8, data bits per frame, LSB first.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  reset, asynchronous assert, active-low; synchronous deassert handled upstream.
baud  in  17  baud select: 4800/9600/14400/19200/38400/57600/115200/128000.
parity_en  in  1  1 = frame carries a parity bit.
parity_odd  in  1  1 = odd parity, 0 = even parity; ignored when parity_en=0.
rx  in  1  serial line, idle high, asynchronous to clk.
rx_ready  in  1  consumer accepts rx_data this cycle.
rx_data  out  DATA_BITS  received byte.
rx_valid  out  1  rx_data and flags are valid; held until accepted.
parity_err  out  1  parity mismatch for the presented byte.
frame_err  out  1  stop bit sampled low for the presented byte.
overrun  out  1  one-cycle pulse: a frame completed while the previous byte was unaccepted.
busy  out  1  FSM not in IDLE.

Behaviour:
- Reset (rst=0, asynchronous):
  - Outputs: rx_data=0, rx_valid=0, parity_err=0, frame_err=0, overrun=0, busy=0.
  - Internal: synchronizer flops=1, FSM=IDLE, all counters=0.
- Input synchronizer: rx goes through a 2-FF synchronizer before any use; 2-cycle latency.
- Divisor = floor(CLK_FREQ/(16*baud)). At 100 MHz: 4800→1302, 9600→651, 14400→434, 19200→325, 38400→162, 57600→108, 115200→54, 128000→48. Any other baud value→651.
- Baud and parity configuration are latched only in IDLE on start detection. Changes mid-frame have no effect until the next frame.
- Tick counter: 0..DIV-1; tick asserts for one clk when count==DIV-1, then the counter wraps to 0. The counter and tick count are cleared on start detection.
- FSM states and transitions:
  - IDLE: synchronized rx falling edge (prev=1, cur=0) → START.
  - START: at the 8th tick, sample rx. rx=1 → false start, back to IDLE with no output. rx=0 → DATA.
  - DATA: sample every 16 ticks, shift in LSB first. After DATA_BITS samples → PARITY if parity_en, else STOP.
  - PARITY: sample after 16 ticks. Error if XOR(data, bit) ≠ parity_odd.
  - STOP: sample after 16 ticks. rx=0 sets frame error. Then go to IDLE if rx=1; otherwise → BREAK.
  - BREAK: wait for synchronized rx=1, then → IDLE. No new start is detected until the line returns high.
- Output: registered one clk after the stop sample.
  - If rx_valid=0, or rx_valid=1 with rx_ready=1 in the same cycle: load rx_data, parity_err, frame_err and set rx_valid=1.
  - Otherwise: pulse overrun for 1 cycle. The new byte and its flags are discarded and the old byte is kept.
- Handshake: rx_valid clears the cycle after rx_valid&rx_ready unless a new load occurs in that same cycle. Error flags are qualified by rx_valid only.
- Frames with frame_err or parity_err are still delivered, with the flag set.
- Reset asserted mid-frame aborts immediately. No partial byte is ever presented.

Decomposition:
- Package uart_pkg:
  - typedef enum rx_state_t {IDLE, START, DATA, PARITY, STOP, BREAK}.
  - OS_RATE=16.
  - Function baud_to_div(baud, clk_freq) implementing the table above.
- Sub-module uart_os_tick: divisor counter plus tick output, with clear input. Reusable by the transmitter.

Test Plan:
1. baud=115200, parity_en=0; send 0xA5 with bit period 864 clks → rx_data=0xA5, rx_valid=1, frame_err=0, parity_err=0. Valid asserts 8208±54 clks after the synchronized falling edge, plus 1.
2. baud=9600, parity_en=1, parity_odd=0; send 0x3C with parity=0 → parity_err=0. Resend with parity=1 → rx_data=0x3C, parity_err=1.
3. 0.3-bit low glitch on idle line at 115200 → no rx_valid, busy returns 0 after mid-start sample, next 0x55 received correctly.
4. Send 0x00 with stop bit low for 3 bit times (break) → rx_data=0x00, frame_err=1. No second frame while line is low. Next 0x81 after line high is received cleanly.
5. rx_ready=0; send 0x11 then 0x22 → rx_data stays 0x11, overrun pulses exactly 1 cycle. Assert rx_ready → rx_valid drops next cycle.
6. Assert rst=0 mid-data of 0xFF at 57600, release, send 0x42 → no output for the aborted frame, then rx_data=0x42. baud=12345 is received at the 9600 rate (div 651).
